// File: rtl/cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cmp_search_ctrl
// Description : Binary-search initiator for a shared magnitude comparator.
//               A request carries an inclusive window [i_req_lo, i_req_hi].
//               Each SEARCH cycle puts a midpoint candidate on o_cmp_a, samples
//               the comparator's eq/gt/lt flags and shrinks the window. The
//               result is held on the rsp_* outputs until it is consumed.
// Ports       : clk, arst            clock, async active-high reset
//               i_req_*/o_req_rdy    search request handshake
//               o_cmp_a/o_cmp_vld    candidate to comparator (target on its B)
//               i_cmp_eq/gt/lt       comparator result flags
//               o_rsp_*/i_rsp_rdy    result handshake and payload
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_search_ctrl #(
  parameter int W = 32
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      i_req_vld,
  input  logic [W-1:0]              i_req_lo,
  input  logic [W-1:0]              i_req_hi,
  output logic                      o_req_rdy,
  output logic [W-1:0]              o_cmp_a,
  output logic                      o_cmp_vld,
  input  logic                      i_cmp_eq,
  input  logic                      i_cmp_gt,
  input  logic                      i_cmp_lt,
  output logic                      o_rsp_vld,
  input  logic                      i_rsp_rdy,
  output logic                      o_rsp_found,
  output logic                      o_rsp_err,
  output logic [W-1:0]              o_rsp_val,
  output logic [$clog2(W + 2)-1:0]  o_rsp_iters
);

  localparam int CNT_W = $clog2(W + 2);

  localparam logic [W-1:0]     c_one_w   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_one_cnt = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [W-1:0]     r_lo, w_lo_nxt;
  logic [W-1:0]     r_hi, w_hi_nxt;
  logic [W-1:0]     r_cand, w_cand_nxt;
  logic [CNT_W-1:0] r_iters, w_iters_nxt;
  logic             r_found, w_found_nxt;
  logic             r_err, w_err_nxt;
  logic [W-1:0]     r_val, w_val_nxt;

  // Midpoint written as lo + half-span so the sum can never exceed hi.
  function automatic logic [W-1:0] f_mid(input logic [W-1:0] lo, input logic [W-1:0] hi);
    f_mid = lo + ((hi - lo) >> 1);
  endfunction

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= S_IDLE;
      r_lo    <= '0;
      r_hi    <= '0;
      r_cand  <= '0;
      r_iters <= '0;
      r_found <= 1'b0;
      r_err   <= 1'b0;
      r_val   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lo    <= w_lo_nxt;
      r_hi    <= w_hi_nxt;
      r_cand  <= w_cand_nxt;
      r_iters <= w_iters_nxt;
      r_found <= w_found_nxt;
      r_err   <= w_err_nxt;
      r_val   <= w_val_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lo_nxt    = r_lo;
    w_hi_nxt    = r_hi;
    w_cand_nxt  = r_cand;
    w_iters_nxt = r_iters;
    w_found_nxt = r_found;
    w_err_nxt   = r_err;
    w_val_nxt   = r_val;

    case (r_state)
      S_IDLE: begin
        if (i_req_vld) begin
          w_iters_nxt = '0;
          w_found_nxt = 1'b0;
          w_err_nxt   = 1'b0;
          w_val_nxt   = '0;
          if (i_req_lo <= i_req_hi) begin
            w_lo_nxt    = i_req_lo;
            w_hi_nxt    = i_req_hi;
            w_cand_nxt  = f_mid(i_req_lo, i_req_hi);
            w_state_nxt = S_SEARCH;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end

      S_SEARCH: begin
        w_iters_nxt = r_iters + c_one_cnt;
        case ({i_cmp_eq, i_cmp_gt, i_cmp_lt})
          3'b100: begin
            w_found_nxt = 1'b1;
            w_val_nxt   = r_cand;
            w_state_nxt = S_DONE;
          end
          3'b010: begin
            // Candidate too big. At cand == lo the window would empty, and
            // stopping here also keeps cand - 1 from wrapping below zero.
            if (r_cand == r_lo) begin
              w_state_nxt = S_DONE;
            end else begin
              w_hi_nxt   = r_cand - c_one_w;
              w_cand_nxt = f_mid(r_lo, r_cand - c_one_w);
            end
          end
          3'b001: begin
            // Candidate too small; symmetric end test keeps cand + 1 in range.
            if (r_cand == r_hi) begin
              w_state_nxt = S_DONE;
            end else begin
              w_lo_nxt   = r_cand + c_one_w;
              w_cand_nxt = f_mid(r_cand + c_one_w, r_hi);
            end
          end
          default: begin
            w_err_nxt   = 1'b1;
            w_found_nxt = 1'b0;
            w_state_nxt = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        if (i_rsp_rdy) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are gated by state so stale result/candidate registers never leak.
  assign o_req_rdy   = (r_state == S_IDLE);
  assign o_cmp_vld   = (r_state == S_SEARCH);
  assign o_cmp_a     = (r_state == S_SEARCH) ? r_cand : '0;
  assign o_rsp_vld   = (r_state == S_DONE);
  assign o_rsp_found = (r_state == S_DONE) & r_found;
  assign o_rsp_err   = (r_state == S_DONE) & r_err;
  assign o_rsp_val   = (r_state == S_DONE && r_found) ? r_val : '0;
  assign o_rsp_iters = (r_state == S_DONE) ? r_iters : '0;

endmodule
`default_nettype wire

// File: tb/tb_cmp_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_search_ctrl
// Description : Self-checking bench for cmp_search_ctrl (W = 8). The comparator
//               is modelled from a target register; expected candidates and
//               results come from a plain integer binary-search model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_search_ctrl;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 2);

  logic             clk = 1'b0;
  logic             arst;
  logic             i_req_vld;
  logic [W-1:0]     i_req_lo;
  logic [W-1:0]     i_req_hi;
  logic             o_req_rdy;
  logic [W-1:0]     o_cmp_a;
  logic             o_cmp_vld;
  logic             i_cmp_eq;
  logic             i_cmp_gt;
  logic             i_cmp_lt;
  logic             o_rsp_vld;
  logic             i_rsp_rdy;
  logic             o_rsp_found;
  logic             o_rsp_err;
  logic [W-1:0]     o_rsp_val;
  logic [CNT_W-1:0] o_rsp_iters;

  logic [W-1:0]     r_target;
  logic             r_force_err;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_cands[$];
  int exp_found;
  int exp_err;
  int exp_val;
  int exp_iters;

  always #5 clk = ~clk;

  // Comparator model; forcing asserts eq and gt together.
  assign i_cmp_eq = r_force_err ? 1'b1 : (o_cmp_a == r_target);
  assign i_cmp_gt = r_force_err ? 1'b1 : (o_cmp_a >  r_target);
  assign i_cmp_lt = r_force_err ? 1'b0 : (o_cmp_a <  r_target);

  cmp_search_ctrl #(.W(W)) u_dut (
    .clk         (clk),
    .arst        (arst),
    .i_req_vld   (i_req_vld),
    .i_req_lo    (i_req_lo),
    .i_req_hi    (i_req_hi),
    .o_req_rdy   (o_req_rdy),
    .o_cmp_a     (o_cmp_a),
    .o_cmp_vld   (o_cmp_vld),
    .i_cmp_eq    (i_cmp_eq),
    .i_cmp_gt    (i_cmp_gt),
    .i_cmp_lt    (i_cmp_lt),
    .o_rsp_vld   (o_rsp_vld),
    .i_rsp_rdy   (i_rsp_rdy),
    .o_rsp_found (o_rsp_found),
    .o_rsp_err   (o_rsp_err),
    .o_rsp_val   (o_rsp_val),
    .o_rsp_iters (o_rsp_iters)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: textbook binary search over unbounded integers. err_at > 0
  // marks the comparison number whose flags are corrupted.
  task automatic model(input int lo, input int hi, input int t, input int err_at);
    int l, h, m;
    exp_cands.delete();
    exp_found = 0;
    exp_err   = 0;
    exp_val   = 0;
    l = lo;
    h = hi;
    while (l <= h) begin
      m = l + (h - l) / 2;
      exp_cands.push_back(m);
      if (err_at == exp_cands.size()) begin
        exp_err = 1;
        break;
      end
      if (m == t) begin
        exp_found = 1;
        exp_val   = m;
        break;
      end else if (m > t) begin
        h = m - 1;
      end else begin
        l = m + 1;
      end
    end
    exp_iters = exp_cands.size();
  endtask

  task automatic check_rsp(input string tag);
    check({tag, "_vld"},   o_rsp_vld,   1);
    check({tag, "_found"}, o_rsp_found, exp_found);
    check({tag, "_err"},   o_rsp_err,   exp_err);
    check({tag, "_val"},   o_rsp_val,   exp_val);
    check({tag, "_iters"}, o_rsp_iters, exp_iters);
  endtask

  // One complete request. Called and returning at a negedge.
  // rst_at > 0: assert arst during that comparison and abandon the request.
  task automatic run_search(input int lo, input int hi, input int t,
                            input int err_at, input int hold, input int rst_at);
    int wait_cyc;
    int cyc;
    int cidx;
    bit seen_rsp;
    model(lo, hi, t, err_at);
    r_target = t[W-1:0];

    wait_cyc = 0;
    while (!o_req_rdy && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!o_req_rdy) begin
      check("req_rdy_timeout", o_req_rdy, 1);
      return;
    end

    i_req_vld = 1'b1;
    i_req_lo  = lo[W-1:0];
    i_req_hi  = hi[W-1:0];
    @(negedge clk);
    i_req_vld = 1'b0;

    cyc  = 1;
    cidx = 0;
    while (!o_rsp_vld && cyc < 60) begin
      if (o_cmp_vld) begin
        if (cidx < exp_cands.size())
          check("cand", o_cmp_a, exp_cands[cidx]);
        else
          check("cmp_vld_extra", o_cmp_vld, 0);
        cidx++;
        if (rst_at > 0 && cidx == rst_at) begin
          arst = 1'b1;
          #1;
          check("rst_req_rdy", o_req_rdy,   1);
          check("rst_cmp_vld", o_cmp_vld,   0);
          check("rst_cmp_a",   o_cmp_a,     0);
          check("rst_rsp_vld", o_rsp_vld,   0);
          check("rst_iters",   o_rsp_iters, 0);
          @(negedge clk);
          arst = 1'b0;
          seen_rsp = 1'b0;
          repeat (10) begin
            @(negedge clk);
            if (o_rsp_vld) seen_rsp = 1'b1;
          end
          check("rst_no_rsp", seen_rsp, 0);
          return;
        end
        r_force_err = (err_at == cidx);
      end
      @(negedge clk);
      cyc++;
    end
    r_force_err = 1'b0;

    if (!o_rsp_vld) begin
      check("rsp_timeout", o_rsp_vld, 1);
      return;
    end
    check("latency", cyc, exp_iters + 1);
    check_rsp("rsp");

    repeat (hold) begin
      @(negedge clk);
      check_rsp("hold");
      check("hold_req_rdy", o_req_rdy, 0);
    end
    i_rsp_rdy = 1'b1;
    @(negedge clk);
    i_rsp_rdy = 1'b0;
    check("rsp_vld_clr",  o_rsp_vld, 0);
    check("req_rdy_back", o_req_rdy, 1);
  endtask

  initial begin
    int lo, hi, t, err_at;
    arst        = 1'b1;
    i_req_vld   = 1'b0;
    i_req_lo    = '0;
    i_req_hi    = '0;
    i_rsp_rdy   = 1'b0;
    r_target    = '0;
    r_force_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_rdy", o_req_rdy,   1);
    check("reset_cmp_vld", o_cmp_vld,   0);
    check("reset_cmp_a",   o_cmp_a,     0);
    check("reset_rsp_vld", o_rsp_vld,   0);
    check("reset_found",   o_rsp_found, 0);
    arst = 1'b0;
    @(negedge clk);

    // Found in the middle, with the response held back for 5 cycles.
    run_search(0, 255, 100, 0, 5, 0);
    // Back-to-back: top of range takes W + 1 comparisons.
    run_search(0, 255, 255, 0, 0, 0);
    // Not found: gt at cand == lo, then lt at cand == hi.
    run_search(5, 255, 2, 0, 1, 0);
    run_search(0, 10, 200, 0, 0, 0);
    // Empty window.
    run_search(9, 3, 50, 0, 0, 0);
    // Corrupt flags on the second comparison.
    run_search(0, 255, 100, 2, 0, 0);
    // Reset during the third comparison, then a fresh search.
    run_search(0, 255, 100, 0, 0, 3);
    run_search(0, 255, 100, 0, 0, 0);
    run_search(0, 0, 0, 0, 0, 0);
    run_search(255, 255, 7, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      lo = $urandom_range(0, 255);
      if ($urandom_range(0, 5) == 0)
        hi = $urandom_range(0, 255);
      else
        hi = lo + $urandom_range(0, 255 - lo);
      if ($urandom_range(0, 1) == 0 && lo <= hi)
        t = $urandom_range(lo, hi);
      else
        t = $urandom_range(0, 255);
      err_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      run_search(lo, hi, t, err_at, $urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
